// File: rtl/alu_and_alu_control_if.sv
// Operand/opcode bundle feeding the ALU and the registered result/flag coming back.
// The master side drives the instruction fields and operands; the slave side is the ALU.
interface alu_and_alu_control_if;
  logic [2:0]  Funct3_i;
  logic [6:0]  Funct7_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] OperandA_i;
  logic [31:0] OperandB_i;
  logic [31:0] Result_o;
  logic        Flag_o;

  modport master (
    output Funct3_i, Funct7_i, ALUOp_i, OperandA_i, OperandB_i,
    input  Result_o, Flag_o
  );

  modport slave (
    input  Funct3_i, Funct7_i, ALUOp_i, OperandA_i, OperandB_i,
    output Result_o, Flag_o
  );
endinterface

// File: rtl/alu_and_alu_control.sv
// RV32I-style ALU with its funct3/funct7/ALUOp control decoder.
// Single registered output stage: result and flag appear one cycle after the inputs.
module alu_and_alu_control (
  input  logic                        Clk_i,
  input  logic                        Rst_ni,
  alu_and_alu_control_if.slave        bus
);

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_PASSB
  } alu_op_e;

  localparam logic [1:0] ALUOP_ARITH  = 2'b00;
  localparam logic [1:0] ALUOP_MEM    = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  alu_op_e             alu_op;
  logic signed [31:0]  opa_s;
  logic signed [31:0]  opb_s;
  logic        [31:0]  opa_u;
  logic        [31:0]  opb_u;
  logic        [4:0]   shamt;
  logic                f7_alt;
  logic        [31:0]  result_d;
  logic        [31:0]  result_q;
  logic                flag_d;
  logic                flag_q;
  logic                branch_taken;

  // Only bit 5 of funct7 distinguishes SUB/SRA; the rest is intentionally dropped.
  logic unused_funct7;
  assign unused_funct7 = ^{bus.Funct7_i[6], bus.Funct7_i[4:0]};

  assign opa_u  = bus.OperandA_i;
  assign opb_u  = bus.OperandB_i;
  assign opa_s  = signed'(bus.OperandA_i);
  assign opb_s  = signed'(bus.OperandB_i);
  assign shamt  = bus.OperandB_i[4:0];
  assign f7_alt = bus.Funct7_i[5];

  function automatic alu_op_e decode_arith(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    alu_op = OP_ADD;
    unique case (bus.ALUOp_i)
      ALUOP_ARITH:  alu_op = decode_arith(bus.Funct3_i, f7_alt);
      ALUOP_MEM:    alu_op = OP_ADD;
      ALUOP_BRANCH: alu_op = OP_SUB;
      default:      alu_op = OP_PASSB;
    endcase
  end

  // Datapath: all arithmetic wraps modulo 2^32.
  always_comb begin
    result_d = '0;
    unique case (alu_op)
      OP_ADD:   result_d = opa_u + opb_u;
      OP_SUB:   result_d = opa_u - opb_u;
      OP_SLL:   result_d = opa_u << shamt;
      OP_SLT:   result_d = {31'd0, (opa_s < opb_s)};
      OP_SLTU:  result_d = {31'd0, (opa_u < opb_u)};
      OP_XOR:   result_d = opa_u ^ opb_u;
      OP_SRL:   result_d = opa_u >> shamt;
      OP_SRA:   result_d = unsigned'(opa_s >>> shamt);
      OP_OR:    result_d = opa_u | opb_u;
      OP_AND:   result_d = opa_u & opb_u;
      default:  result_d = opb_u;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    unique case (bus.Funct3_i)
      3'b000:  branch_taken = (opa_u == opb_u);
      3'b001:  branch_taken = (opa_u != opb_u);
      3'b100:  branch_taken = (opa_s <  opb_s);
      3'b101:  branch_taken = (opa_s >= opb_s);
      3'b110:  branch_taken = (opa_u <  opb_u);
      3'b111:  branch_taken = (opa_u >= opb_u);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    flag_d = (result_d == 32'd0);
    if (bus.ALUOp_i == ALUOP_BRANCH) begin
      flag_d = branch_taken;
    end
  end

  // Output register stage
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.Result_o = result_q;
  assign bus.Flag_o   = flag_q;

endmodule

// File: tb/tb_alu_and_alu_control.sv
// Scoreboard bench for alu_and_alu_control: expectations are queued when a vector is
// driven and retired when the registered result appears one cycle later.
module tb_alu_and_alu_control;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        flg;
  } exp_t;

  logic Clk_i;
  logic Rst_ni;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  alu_and_alu_control_if bus ();

  alu_and_alu_control dut (
    .Clk_i  (Clk_i),
    .Rst_ni (Rst_ni),
    .bus    (bus.slave)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent behavioural reference written from the instruction semantics.
  function automatic logic [32:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    int signed   sa;
    int signed   sb_;
    sa  = a;
    sb_ = b;
    r   = 32'd0;
    f   = 1'b0;
    if (op == 2'b00) begin
      case (f3)
        3'd0: r = f7[5] ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb_) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      f = (r == 0);
    end else if (op == 2'b01) begin
      r = a + b;
      f = (r == 0);
    end else if (op == 2'b10) begin
      r = a - b;
      case (f3)
        3'd0: f = (a == b);
        3'd1: f = (a != b);
        3'd4: f = (sa < sb_);
        3'd5: f = (sa >= sb_);
        3'd6: f = (a < b);
        3'd7: f = (a >= b);
        default: f = 1'b0;
      endcase
    end else begin
      r = b;
      f = (r == 0);
    end
    return {f, r};
  endfunction

  task automatic retire();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".res"}, bus.Result_o, e.res);
      check_eq({e.tag, ".flag"}, {31'd0, bus.Flag_o}, {31'd0, e.flg});
    end
  endtask

  task automatic send(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_f);
    exp_t e;
    @(negedge Clk_i);
    retire();
    bus.ALUOp_i    = op;
    bus.Funct3_i   = f3;
    bus.Funct7_i   = f7;
    bus.OperandA_i = a;
    bus.OperandB_i = b;
    e.tag = tag;
    e.res = exp_r;
    e.flg = exp_f;
    sb.push_back(e);
  endtask

  task automatic send_model(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = ref_alu(op, f3, f7, a, b);
    send(tag, op, f3, f7, a, b, m[31:0], m[32]);
  endtask

  task automatic flush();
    @(negedge Clk_i);
    retire();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst_ni = 1'b0;
    bus.ALUOp_i    = 2'b00;
    bus.Funct3_i   = 3'd0;
    bus.Funct7_i   = 7'd0;
    bus.OperandA_i = 32'd20;
    bus.OperandB_i = 32'd30;
    repeat (2) @(posedge Clk_i);
    #1;
    check_eq("rst.res", bus.Result_o, 32'd0);
    check_eq("rst.flag", {31'd0, bus.Flag_o}, 32'd0);
    @(negedge Clk_i);
    Rst_ni = 1'b1;

    send("add",  2'b00, 3'b000, 7'h00, 32'd20, 32'd30, 32'd50, 1'b0);
    send("sub",  2'b00, 3'b000, 7'h20, 32'd20, 32'd30, 32'hFFFF_FFF6, 1'b0);
    send("sll",  2'b00, 3'b001, 7'h00, 32'd5, 32'd2, 32'd20, 1'b0);
    send("xor",  2'b00, 3'b100, 7'h00, 32'd3, 32'd5, 32'd6, 1'b0);
    send("xor7", 2'b00, 3'b100, 7'h20, 32'd3, 32'd5, 32'd6, 1'b0);
    send("srl",  2'b00, 3'b101, 7'h00, 32'd20, 32'd2, 32'd5, 1'b0);
    send("sra",  2'b00, 3'b101, 7'h20, 32'hFFFF_FFEC, 32'd2, 32'hFFFF_FFFB, 1'b0);
    send("sra5", 2'b00, 3'b101, 7'h20, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send("or",   2'b00, 3'b110, 7'h00, 32'd8, 32'd5, 32'd13, 1'b0);
    send("and",  2'b00, 3'b111, 7'h00, 32'd8, 32'd5, 32'd0, 1'b1);
    send("slt",  2'b00, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    send("sltu", 2'b00, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    send("addw", 2'b00, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    send("mem",  2'b01, 3'b111, 7'h20, 32'd20, 32'd30, 32'd50, 1'b0);
    send("beq",  2'b10, 3'b000, 7'h00, 32'd20, 32'd20, 32'd0, 1'b1);
    send("beqn", 2'b10, 3'b000, 7'h00, 32'd20, 32'd21, 32'hFFFF_FFFF, 1'b0);
    send("bne",  2'b10, 3'b001, 7'h00, 32'd20, 32'd21, 32'hFFFF_FFFF, 1'b1);
    send("blt",  2'b10, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
    send("bge",  2'b10, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
    send("bltu", 2'b10, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
    send("bgeu", 2'b10, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
    send("b010", 2'b10, 3'b010, 7'h00, 32'd7, 32'd7, 32'd0, 1'b0);
    send("lui",  2'b11, 3'b100, 7'h00, 32'd30, 32'd5, 32'd5, 1'b0);
    send("lui0", 2'b11, 3'b000, 7'h20, 32'd30, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      send_model($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 7'($urandom), $urandom, $urandom);
    end

    // Async reset while holding a nonzero result.
    send("pre", 2'b00, 3'b000, 7'h00, 32'd20, 32'd30, 32'd50, 1'b0);
    flush();
    #2 Rst_ni = 1'b0;
    #1;
    check_eq("arst.res", bus.Result_o, 32'd0);
    check_eq("arst.flag", {31'd0, bus.Flag_o}, 32'd0);
    @(posedge Clk_i);
    #1;
    check_eq("hold.res", bus.Result_o, 32'd0);
    Rst_ni = 1'b1;
    send("post", 2'b00, 3'b110, 7'h00, 32'd8, 32'd5, 32'd13, 1'b0);
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_and_alu_control.md
ALU_AND_ALU_CONTROL -- requirements
Module: alu_and_alu_control

Interface
REQ-001 SHALL have one clock and reset that is asynchronous and active-low.
REQ-002 Clk_i  input  1  clock; all state updates on rising edge.
REQ-003 Rst_ni  input  1  asynchronous active-low reset.
REQ-004 Funct3_i  input  3  instruction funct3 field.
REQ-005 Funct7_i  input  7  instruction funct7 field; only bit 5 is decoded.
REQ-006 ALUOp_i  input  2  operation class: 00 R/I-arith, 01 load/store, 10 branch, 11 LUI.
REQ-007 OperandA_i  input  32  operand A (rs1).
REQ-008 OperandB_i  input  32  operand B (rs2 or immediate).
REQ-009 Result_o  output  32  registered ALU result.
REQ-010 Flag_o  output  1  registered flag: branch condition when ALUOp=10, else zero flag.
REQ-011 SHALL have no parameters; data width fixed at 32.

Function
REQ-012 Internal ALU-control decoder SHALL be combinational, mapping {ALUOp_i, Funct3_i, Funct7_i[5]} to an ALU operation code.
REQ-013 Result and flag SHALL be computed combinationally and captured into Result_o/Flag_o on every rising Clk_i edge; latency exactly 1 cycle, throughput 1 op/cycle, no handshake.
REQ-014 ALUOp=00, Funct3: 000 ADD (Funct7[5]=0) or SUB (Funct7[5]=1); 001 SLL; 010 SLT (signed, result 1/0); 011 SLTU (unsigned, 1/0); 100 XOR; 101 SRL (Funct7[5]=0) or SRA (Funct7[5]=1); 110 OR; 111 AND.
REQ-015 Shifts SHALL use OperandB_i[4:0] only; SRA replicates OperandA_i[31].
REQ-016 ADD/SUB SHALL wrap modulo 2^32; no overflow/carry output.
REQ-017 Funct7[5] SHALL be ignored for Funct3 other than 000 and 101.
REQ-018 ALUOp=01 SHALL produce Result = A + B (address), regardless of Funct3/Funct7.
REQ-019 ALUOp=10 SHALL produce Result = A - B and Flag per Funct3: 000 BEQ (A==B), 001 BNE (A!=B), 100 BLT (signed A<B), 101 BGE (signed A>=B), 110 BLTU (unsigned A<B), 111 BGEU (unsigned A>=B); 010/011 SHALL give Flag=0.
REQ-020 ALUOp=11 (LUI) SHALL produce Result = OperandB_i unchanged; Funct3/Funct7/OperandA ignored.
REQ-021 For ALUOp other than 10, Flag SHALL be 1 iff the computed 32-bit Result equals 0.
REQ-022 Input changes between edges SHALL not affect outputs until the next rising edge.

Reset
REQ-023 Rst_ni low SHALL immediately (without clock) force Result_o=0 and Flag_o=0.
REQ-024 While Rst_ni low, outputs SHALL hold 0; first capture occurs on first rising edge after Rst_ni deasserts.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; no other state exists.

Verification
REQ-026 ALUOp=00, F3=000, F7=0000000, A=20, B=30 -> next cycle Result=50, Flag=0; with F7=0100000 -> Result=-10 (0xFFFFFFF6), Flag=0.
REQ-027 ALUOp=00: F3=001 A=5 B=2 -> 20; F3=100 A=3 B=5 -> 6; F3=101 F7=0 A=20 B=2 -> 5; F3=101 F7=0100000 A=-20 B=2 -> -5; F3=110 A=8 B=5 -> 13; F3=111 A=8 B=5 -> 0 with Flag=1.
REQ-028 ALUOp=01, A=20, B=30 (any funct) -> Result=50, Flag=0.
REQ-029 ALUOp=10, F3=000: A=20 B=20 -> Flag=1, Result=0; A=20 B=21 -> Flag=0; F3=100 A=-1 B=1 -> Flag=1; F3=110 A=-1 B=1 -> Flag=0.
REQ-030 ALUOp=11, F3=100, A=30, B=5 -> Result=5, Flag=0.
REQ-031 Drive Rst_ni low asynchronously while Result_o nonzero -> Result_o=0, Flag_o=0 before next clock edge; release -> valid result one edge later.
